// File: rtl/mcs4_bus_master.sv
// mcs4_bus_master: MCS-4 bus initiator, 8-phase cycle, SYNC/CM-RAM, data mux.
// Optional SRC-before-IO check enabled with `define MCS4_SRC_CHECK_EN.
module mcs4_bus_master #(
  parameter logic [3:0] NOP_OPR = 4'h0,
  parameter logic [3:0] NOP_OPA = 4'h0
) (
  input  logic        cp2,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_pc,
  input  logic [3:0]  cmd_opr,
  input  logic [3:0]  cmd_opa,
  input  logic [7:0]  cmd_x,
  input  logic [1:0]  cmd_bank,
  inout  wire  [3:0]  data,
  output logic        sync,
  output logic [3:0]  cm_ram,
  output logic        rd_valid,
  output logic [3:0]  rd_data,
  output logic        cmd_err
);

  typedef enum logic [7:0] {
    PH_A1 = 8'h01,
    PH_A2 = 8'h02,
    PH_A3 = 8'h04,
    PH_M1 = 8'h08,
    PH_M2 = 8'h10,
    PH_X1 = 8'h20,
    PH_X2 = 8'h40,
    PH_X3 = 8'h80
  } phase_t;

  phase_t      phase_q, phase_d;
  logic        act_q, act_d;
  logic [11:0] pc_q, pc_d;
  logic [3:0]  opr_q, opr_d;
  logic [3:0]  opa_q, opa_d;
  logic [7:0]  x_q, x_d;
  logic [1:0]  bank_q, bank_d;
  logic        oe_q, oe_d;
  logic [3:0]  do_q, do_d;
  logic        sync_q, sync_d;
  logic [3:0]  cm_q, cm_d;
  logic        rdv_q, rdv_d;
  logic [3:0]  rdd_q, rdd_d;
  logic        rej;
  logic        src_d, io_d, rd_d;
  logic [3:0]  oh;
`ifdef MCS4_SRC_CHECK_EN
  logic        armed_q, armed_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    phase_d = PH_A1;
    unique case (phase_q)
      PH_A1:   phase_d = PH_A2;
      PH_A2:   phase_d = PH_A3;
      PH_A3:   phase_d = PH_M1;
      PH_M1:   phase_d = PH_M2;
      PH_M2:   phase_d = PH_X1;
      PH_X1:   phase_d = PH_X2;
      PH_X2:   phase_d = PH_X3;
      default: phase_d = PH_A1;
    endcase
    act_d  = act_q;
    pc_d   = pc_q;
    opr_d  = opr_q;
    opa_d  = opa_q;
    x_d    = x_q;
    bank_d = bank_q;
    rej    = 1'b0;
`ifdef MCS4_SRC_CHECK_EN
    armed_d = armed_q;
    err_d   = 1'b0;
    rej     = (phase_q == PH_X3) && cmd_valid
              && cmd_opr == 4'hE && !armed_q;
    err_d   = rej;
`endif
    if (phase_q == PH_X3) begin
      act_d = cmd_valid && !rej;
      if (act_d) begin
        pc_d   = cmd_pc;
        opr_d  = cmd_opr;
        opa_d  = cmd_opa;
        x_d    = cmd_x;
        bank_d = cmd_bank;
      end else begin
        opr_d = NOP_OPR;
        opa_d = NOP_OPA;
      end
    end
    src_d = act_d && opr_d == 4'h2 && opa_d[0];
    io_d  = act_d && opr_d == 4'hE;
    rd_d  = io_d && opa_d[3];
`ifdef MCS4_SRC_CHECK_EN
    if (phase_q == PH_X3) armed_d = src_d;
`endif
    oh   = 4'b0001 << bank_d;
    oe_d = 1'b0;
    do_d = 4'h0;
    cm_d = 4'h0;
    unique case (phase_d)
      PH_A1: begin oe_d = 1'b1; do_d = pc_d[3:0]; end
      PH_A2: begin oe_d = 1'b1; do_d = pc_d[7:4]; end
      PH_A3: begin oe_d = 1'b1; do_d = pc_d[11:8]; end
      PH_M1: begin oe_d = 1'b1; do_d = opr_d; end
      PH_M2: begin
        oe_d = 1'b1;
        do_d = opa_d;
        if (io_d) cm_d = oh;
      end
      PH_X1: oe_d = 1'b0;
      PH_X2: begin
        // IO reads leave the bus to the responder
        oe_d = src_d || (io_d && !rd_d);
        do_d = x_d[3:0];
        if (src_d || io_d) cm_d = oh;
      end
      default: begin
        oe_d = src_d;
        do_d = x_d[7:4];
      end
    endcase
    sync_d = (phase_d == PH_X3);
    rdv_d  = (phase_q == PH_X2) && rd_d;
    rdd_d  = rdv_d ? data : rdd_q;
  end

  always_ff @(posedge cp2 or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_X3;
      act_q   <= 1'b0;
      pc_q    <= 12'h000;
      opr_q   <= 4'h0;
      opa_q   <= 4'h0;
      x_q     <= 8'h00;
      bank_q  <= 2'd0;
      oe_q    <= 1'b0;
      do_q    <= 4'h0;
      sync_q  <= 1'b0;
      cm_q    <= 4'h0;
      rdv_q   <= 1'b0;
      rdd_q   <= 4'h0;
`ifdef MCS4_SRC_CHECK_EN
      armed_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      act_q   <= act_d;
      pc_q    <= pc_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      x_q     <= x_d;
      bank_q  <= bank_d;
      oe_q    <= oe_d;
      do_q    <= do_d;
      sync_q  <= sync_d;
      cm_q    <= cm_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
`ifdef MCS4_SRC_CHECK_EN
      armed_q <= armed_d;
      err_q   <= err_d;
`endif
    end
  end

  assign data      = oe_q ? do_q : 4'bzzzz;
  assign cmd_ready = (phase_q == PH_X3);
  assign sync      = sync_q;
  assign cm_ram    = cm_q;
  assign rd_valid  = rdv_q;
  assign rd_data   = rdd_q;
`ifdef MCS4_SRC_CHECK_EN
  assign cmd_err = err_q;
`else
  assign cmd_err = 1'b0;
`endif

endmodule
